// File: rtl/multi_channel_reader.sv
// Sequences several memory regions, in index order, onto one AXI4 read port and one AXI4-Stream.
// Cacheable channels whose key matches the previous run are skipped.
module multi_channel_reader #(
    parameter int unsigned                 C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned                 C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned                 C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned                 C_NUM_CHANNELS     = 2,
    parameter int unsigned                 C_BURST_LEN        = 64,
    parameter int unsigned                 C_MAX_OUTSTANDING  = 8,
    parameter logic [C_NUM_CHANNELS-1:0]   C_CACHE_MASK       = 'b01,
    localparam int unsigned TW = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1
) (
    input  logic                                         data_clk,
    input  logic                                         data_rst_n,
    input  logic                                         ctrl_start,
    output logic                                         ctrl_done,
    output logic                                         ctrl_busy,
    input  logic [64*C_NUM_CHANNELS-1:0]                 ch_key,
    input  logic [C_M_AXI_ADDR_WIDTH*C_NUM_CHANNELS-1:0] ch_addr,
    input  logic [C_XFER_SIZE_WIDTH*C_NUM_CHANNELS-1:0]  ch_size,
    output logic                                         m_axi_arvalid,
    input  logic                                         m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                m_axi_araddr,
    output logic [7:0]                                   m_axi_arlen,
    input  logic                                         m_axi_rvalid,
    output logic                                         m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]                m_axi_rdata,
    input  logic                                         m_axi_rlast,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                         m_axis_tlast,
    output logic [TW-1:0]                                m_axis_ttype
);

    localparam int unsigned AW  = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW  = C_XFER_SIZE_WIDTH;
    localparam int unsigned BB  = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned LBB = $clog2(BB);
    localparam int unsigned CW  = $clog2(C_NUM_CHANNELS + 1);
    localparam int unsigned OW  = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {StIdle, StSelect, StRun, StDone} state_e;

    state_e                    r_state, w_state_next;
    logic [AW-1:0]             r_base [C_NUM_CHANNELS];
    logic [XW-1:0]             r_beats [C_NUM_CHANNELS];
    logic [63:0]               r_key [C_NUM_CHANNELS];
    logic [C_NUM_CHANNELS-1:0] r_key_valid, r_skip;
    logic [CW-1:0]             r_cur;
    logic [AW-1:0]             r_req_addr;
    logic [XW-1:0]             r_req_rem, r_beats_cur, r_beat_cnt;
    logic [OW-1:0]             r_outstanding;

    logic                      w_found, w_run, w_arvalid, w_ar_hs, w_r_hs, w_last_beat;
    logic [TW-1:0]             w_sel_idx;
    logic [12:0]               w_to4k_bytes;
    logic [XW-1:0]             w_to4k_beats, w_burst;

    // Lowest unskipped channel at or above the current index
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        for (int i = int'(C_NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (CW'(i) >= r_cur && !r_skip[i]) begin
                w_found   = 1'b1;
                w_sel_idx = TW'(i);
            end
        end
    end

    assign w_run        = (r_state == StRun);
    assign w_to4k_bytes = 13'h1000 - {1'b0, r_req_addr[11:0]};
    assign w_to4k_beats = XW'(w_to4k_bytes >> LBB);

    always_comb begin
        w_burst = r_req_rem;
        if (w_burst > XW'(C_BURST_LEN)) w_burst = XW'(C_BURST_LEN);
        if (w_burst > w_to4k_beats)     w_burst = w_to4k_beats;
    end

    assign w_arvalid   = w_run && (r_req_rem != '0) && (r_outstanding < OW'(C_MAX_OUTSTANDING));
    assign w_ar_hs     = w_arvalid && m_axi_arready;
    assign w_r_hs      = m_axi_rvalid && m_axis_tready && w_run;
    assign w_last_beat = (r_beat_cnt == r_beats_cur - XW'(1));

    assign m_axi_arvalid = w_arvalid;
    assign m_axi_araddr  = w_arvalid ? r_req_addr : '0;
    assign m_axi_arlen   = w_arvalid ? 8'(w_burst - XW'(1)) : '0;
    assign m_axi_rready  = m_axis_tready && w_run;
    assign m_axis_tvalid = m_axi_rvalid && w_run;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = m_axis_tvalid && w_last_beat;
    assign m_axis_ttype  = w_run ? r_cur[TW-1:0] : '0;
    assign ctrl_done     = (r_state == StDone);
    assign ctrl_busy     = (r_state != StIdle);

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) r_state <= StIdle;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (ctrl_start) w_state_next = StSelect;
            StSelect: w_state_next = w_found ? StRun : StDone;
            StRun:    if (w_r_hs && w_last_beat) w_state_next = StSelect;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            for (int i = 0; i < int'(C_NUM_CHANNELS); i++) begin
                r_base[i]  <= '0;
                r_beats[i] <= '0;
                r_key[i]   <= '0;
            end
            r_key_valid   <= '0;
            r_skip        <= '0;
            r_cur         <= '0;
            r_req_addr    <= '0;
            r_req_rem     <= '0;
            r_beats_cur   <= '0;
            r_beat_cnt    <= '0;
            r_outstanding <= '0;
        end else begin
            case (r_state)
                StIdle: if (ctrl_start) begin
                    r_cur      <= '0;
                    r_beat_cnt <= '0;
                    for (int i = 0; i < int'(C_NUM_CHANNELS); i++) begin
                        r_base[i]  <= ch_addr[i*AW +: AW] & ~AW'(BB - 1);
                        r_beats[i] <= ch_size[i*XW +: XW] >> LBB;
                        // Skip test uses the key stored by the previous run
                        r_skip[i]  <= ((ch_size[i*XW +: XW] >> LBB) == '0) ||
                                      (C_CACHE_MASK[i] && r_key_valid[i] &&
                                       (ch_key[i*64 +: 64] == r_key[i]));
                        if (C_CACHE_MASK[i]) begin
                            r_key[i]       <= ch_key[i*64 +: 64];
                            r_key_valid[i] <= 1'b1;
                        end
                    end
                end
                StSelect: if (w_found) begin
                    r_cur       <= CW'(w_sel_idx);
                    r_req_addr  <= r_base[w_sel_idx];
                    r_req_rem   <= r_beats[w_sel_idx];
                    r_beats_cur <= r_beats[w_sel_idx];
                    r_beat_cnt  <= '0;
                end
                StRun: begin
                    if (w_ar_hs) begin
                        r_req_addr <= r_req_addr + (AW'(w_burst) << LBB);
                        r_req_rem  <= r_req_rem - w_burst;
                    end
                    if (w_r_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_cur      <= r_cur + CW'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + XW'(1);
                        end
                    end
                end
                default: r_beat_cnt <= '0;
            endcase

            case ({w_ar_hs, w_r_hs && m_axi_rlast})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_reader.sv
// Randomised bench for multi_channel_reader: AXI slave model plus a run-level reference model
// that predicts the AR bursts and stream beats of every run.
module tb_multi_channel_reader;

    localparam int N    = 2;
    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int XW   = 32;
    localparam int BL   = 64;
    localparam int MAXO = 2;

    logic              data_clk = 1'b0;
    logic              data_rst_n = 1'b0;
    logic              ctrl_start = 1'b0;
    logic              ctrl_done, ctrl_busy;
    logic [64*N-1:0]   ch_key = '0;
    logic [AW*N-1:0]   ch_addr = '0;
    logic [XW*N-1:0]   ch_size = '0;
    logic              m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast;
    logic              m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic              m_axis_tready = 1'b0;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [DW-1:0]     m_axi_rdata = '0, m_axis_tdata;
    logic [0:0]        m_axis_ttype;

    multi_channel_reader #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_XFER_SIZE_WIDTH  (XW),
        .C_NUM_CHANNELS     (N),
        .C_BURST_LEN        (BL),
        .C_MAX_OUTSTANDING  (MAXO),
        .C_CACHE_MASK       (2'b01)
    ) dut (
        .data_clk      (data_clk),
        .data_rst_n    (data_rst_n),
        .ctrl_start    (ctrl_start),
        .ctrl_done     (ctrl_done),
        .ctrl_busy     (ctrl_busy),
        .ch_key        (ch_key),
        .ch_addr       (ch_addr),
        .ch_size       (ch_size),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rlast   (m_axi_rlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_ttype  (m_axis_ttype)
    );

    always #5 data_clk = ~data_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [63:0] a);
        return {8{a ^ 64'h5a5a_0000_c3c3_0000}};
    endfunction

    typedef struct { logic [63:0] addr; int len; } ar_t;
    typedef struct { logic [DW-1:0] data; int ttype; bit last; } beat_t;

    ar_t         exp_ar[$];
    beat_t       exp_beats[$];
    logic [63:0] mdl_key[N];
    bit          mdl_kv[N];
    logic [1:0]  mask_v = 2'b01;

    int ar_pct = 100, rv_pct = 100, t_pct = 100;

    logic [63:0] sl_addr[$];
    int          sl_len[$];
    int          sl_beat = 0;

    int          cyc = 0, outst = 0, done_cnt = 0, done_cyc = 0, last_beat_cyc = 0;
    bit          ar_fire, r_fire, ar_hold = 0;
    logic [63:0] hold_addr;
    logic [7:0]  hold_len;
    ar_t         cur_ar;
    beat_t       cur_b;

    // Monitor on the falling edge, slave/driver updates just after the rising edge
    always begin
        @(negedge data_clk);
        cyc++;
        ar_fire = 0;
        r_fire  = 0;
        if (!data_rst_n) begin
            outst   = 0;
            ar_hold = 0;
        end else begin
            ar_fire = m_axi_arvalid && m_axi_arready;
            r_fire  = m_axi_rvalid && m_axi_rready;
            if (ar_hold)
                chk("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen},
                    {1'b1, hold_addr, hold_len});
            ar_hold   = m_axi_arvalid && !m_axi_arready;
            hold_addr = m_axi_araddr;
            hold_len  = m_axi_arlen;
            if (m_axis_tvalid) chk("rready_mirror", m_axi_rready, m_axis_tready);
            if (ar_fire) begin
                chk("ar_expected", exp_ar.size() > 0, 1);
                if (exp_ar.size() > 0) begin
                    cur_ar = exp_ar.pop_front();
                    chk("araddr", m_axi_araddr, cur_ar.addr);
                    chk("arlen", m_axi_arlen, cur_ar.len);
                end
                outst++;
                chk("outst_le_max", outst <= MAXO, 1);
            end
            if (r_fire) begin
                last_beat_cyc = cyc;
                chk("beat_expected", exp_beats.size() > 0, 1);
                if (exp_beats.size() > 0) begin
                    cur_b = exp_beats.pop_front();
                    chk("tdata", m_axis_tdata, cur_b.data);
                    chk("ttype", m_axis_ttype, cur_b.ttype);
                    chk("tlast", m_axis_tlast, cur_b.last);
                end
                if (m_axi_rlast) outst--;
            end
            if (ctrl_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end

        @(posedge data_clk);
        #1;
        if (!data_rst_n) begin
            sl_addr.delete();
            sl_len.delete();
            sl_beat      = 0;
            m_axi_rvalid = 0;
            m_axi_rlast  = 0;
        end else begin
            if (r_fire) begin
                if (sl_beat == sl_len[0]) begin
                    void'(sl_addr.pop_front());
                    void'(sl_len.pop_front());
                    sl_beat = 0;
                end else begin
                    sl_beat++;
                end
            end
            if (ar_fire) begin
                sl_addr.push_back(hold_addr);
                sl_len.push_back(int'(hold_len));
            end
            if (!(m_axi_rvalid && !r_fire)) begin
                if (sl_addr.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mkdata(sl_addr[0] + 64'(sl_beat) * 64);
                    m_axi_rlast  = (sl_beat == sl_len[0]);
                end else begin
                    m_axi_rvalid = 0;
                    m_axi_rlast  = 0;
                end
            end
        end
        m_axi_arready = ($urandom_range(0, 99) < ar_pct);
        m_axis_tready = ($urandom_range(0, 99) < t_pct);
    end

    task automatic model_build(input logic [63:0] k0, k1, a0, a1, input int unsigned s0, s1,
                               output bit any);
        logic [63:0] k[N], a[N], addr, base;
        int unsigned s[N];
        int beats, rem, lim, sz;
        bit skip;
        k[0] = k0; k[1] = k1; a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1;
        any = 0;
        for (int i = 0; i < N; i++) begin
            beats = int'(s[i] / 64);
            skip  = (beats == 0) || (mask_v[i] && mdl_kv[i] && mdl_key[i] == k[i]);
            if (mask_v[i]) begin
                mdl_key[i] = k[i];
                mdl_kv[i]  = 1;
            end
            if (!skip) begin
                any  = 1;
                base = a[i] & ~64'h3f;
                addr = base;
                rem  = beats;
                while (rem > 0) begin
                    lim = int'((64'd4096 - (addr & 64'hfff)) / 64);
                    sz  = rem;
                    if (sz > BL)  sz = BL;
                    if (sz > lim) sz = lim;
                    exp_ar.push_back('{addr: addr, len: sz - 1});
                    addr = addr + 64'(sz) * 64;
                    rem  = rem - sz;
                end
                for (int b = 0; b < beats; b++) begin
                    beat_t e;
                    e.data  = mkdata(base + 64'(b) * 64);
                    e.ttype = i;
                    e.last  = (b == beats - 1);
                    exp_beats.push_back(e);
                end
            end
        end
        ch_key  = {k1, k0};
        ch_addr = {a1, a0};
        ch_size = {s1, s0};
    endtask

    task automatic pulse_start();
        @(posedge data_clk); #1 ctrl_start = 1;
        @(posedge data_clk); #1 ctrl_start = 0;
    endtask

    task automatic run(input logic [63:0] k0, k1, a0, a1, input int unsigned s0, s1);
        bit any;
        int t, d0;
        model_build(k0, k1, a0, a1, s0, s1, any);
        d0 = done_cnt;
        pulse_start();
        @(negedge data_clk);
        chk("busy_in_select", ctrl_busy, 1);
        chk("no_ar_in_select", m_axi_arvalid, 0);
        @(negedge data_clk);
        if (any) chk("first_ar_cycle2", m_axi_arvalid, 1);
        else     chk("all_skip_done", ctrl_done, 1);
        t = 0;
        while (!ctrl_done && t < 20000) begin
            @(negedge data_clk);
            t++;
        end
        chk("done_seen", ctrl_done, 1);
        @(negedge data_clk);
        chk("done_one_cycle", ctrl_done, 0);
        chk("busy_after_done", ctrl_busy, 0);
        if (any) chk("done_latency", done_cyc - last_beat_cyc, 2);
        chk("done_count", done_cnt - d0, 1);
        chk("ars_left", exp_ar.size(), 0);
        chk("beats_left", exp_beats.size(), 0);
    endtask

    task automatic reset_mid(input logic [63:0] k0, a0, input int unsigned s0);
        bit any;
        model_build(k0, 64'h0, a0, 64'h0, s0, 0, any);
        pulse_start();
        repeat (12) @(negedge data_clk);
        chk("busy_before_reset", ctrl_busy, 1);
        #2 data_rst_n = 0;
        #1;
        chk("rst_ar_outputs", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, 0);
        chk("rst_stream_outputs", {m_axi_rready, m_axis_tvalid, m_axis_tlast, m_axis_ttype}, 0);
        chk("rst_ctrl_outputs", {ctrl_done, ctrl_busy}, 0);
        exp_ar.delete();
        exp_beats.delete();
        for (int i = 0; i < N; i++) mdl_kv[i] = 0;
        repeat (2) @(negedge data_clk);
        data_rst_n = 1;
        repeat (2) @(negedge data_clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mdl_key[i] = '0;
            mdl_kv[i]  = 0;
        end
        #12;
        chk("reset_outputs", {m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
                              m_axis_tvalid, m_axis_tlast, m_axis_ttype, ctrl_done, ctrl_busy}, 0);
        @(negedge data_clk);
        data_rst_n = 1;
        repeat (3) @(negedge data_clk);

        run(64'h11, 64'h22, 64'h1000, 64'h2000, 256, 128);
        run(64'h11, 64'h22, 64'h1000, 64'h2000, 256, 128);
        run(64'h12, 64'h22, 64'h1000, 64'h2000, 256, 0);
        run(64'h13, 64'h22, 64'h0FC0, 64'h2000, 512, 0);

        rv_pct = 25;
        run(64'h14, 64'h23, 64'h10000, 64'h3000, 12800, 64);
        rv_pct = 100;
        run(64'h14, 64'h0, 64'h0, 64'h0, 12800, 0);

        t_pct = 50; ar_pct = 50; rv_pct = 70;
        run(64'h15, 64'h24, 64'h3000, 64'h5047, 1024, 300);

        t_pct = 100; ar_pct = 100; rv_pct = 50;
        reset_mid(64'h16, 64'h8000, 2048);
        run(64'h16, 64'h25, 64'h8000, 64'h9000, 2048, 128);

        t_pct = 80; ar_pct = 70; rv_pct = 60;
        for (int it = 0; it < 4; it++) begin
            run(64'($urandom_range(1, 2)), 64'($urandom), 64'($urandom_range(0, 1048575)),
                64'($urandom_range(0, 1048575)), $urandom_range(0, 6000),
                $urandom_range(0, 3000));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
